// File: rtl/reg_arbiter.sv
// ---------------------------------------------------------------------------
// reg_arbiter
//
// Purpose:
//   Owns the chip configuration register file (REGCOUNT x 8-bit). It
//   arbitrates single-cycle read/write accesses between two requesters:
//     port A : I2C slave engine
//     port B : parallel-input capture logic
//   The whole file is exported flat on registers_packed for the IO/PWM
//   datapath.
//
// Build option:
//   REG_ARB_ROUND_ROBIN_EN  defined   -> on contention, the port that was
//                                        not granted most recently wins.
//                           undefined -> fixed priority, A wins contention.
//
// Ports:
//   clock             chip clock, all state on posedge
//   reset             synchronous, active-high
//   a_req/a_we/a_addr/a_wdata   port A request (req held until a_gnt)
//   a_gnt/a_rdata               port A grant pulse / read data
//   b_req/b_we/b_addr/b_wdata   port B request (req held until b_gnt)
//   b_gnt/b_rdata               port B grant pulse / read data
//   registers_packed            register i at bits [8i+7:8i]
//
// Timing:
//   The selection and the commit happen in the cycle before the grant. gnt
//   is high for one cycle. In that cycle a write is already visible on
//   registers_packed and read data is presented on X_rdata. X_rdata holds
//   until the next read grant to the same port.
// ---------------------------------------------------------------------------
module reg_arbiter #(
    parameter int REGCOUNT = 16,
    parameter int ADDR_W   = 4
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [7:0]            a_wdata,
    output logic                  a_gnt,
    output logic [7:0]            a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [7:0]            b_wdata,
    output logic                  b_gnt,
    output logic [7:0]            b_rdata,

    output logic [8*REGCOUNT-1:0] registers_packed
);

    // Register count widened by one bit so that REGCOUNT == 2**ADDR_W still
    // compares correctly against an ADDR_W-bit address.
    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(REGCOUNT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0] regs_q [REGCOUNT];

    logic       a_gnt_q,   a_gnt_d;
    logic       b_gnt_q,   b_gnt_d;
    logic [7:0] a_rdata_q, a_rdata_d;
    logic [7:0] b_rdata_q, b_rdata_d;

    // ------------------------------------------------------------------
    // Eligibility: a port that is being granted this cycle still has req
    // high. Masking it with its own gnt keeps it from being granted twice
    // in a row. This bounds every wait to two cycles.
    // ------------------------------------------------------------------
    logic a_elig;
    logic b_elig;

    assign a_elig = a_req & ~a_gnt_q;
    assign b_elig = b_req & ~b_gnt_q;

    logic sel_a;
    logic sel_b;

`ifdef REG_ARB_ROUND_ROBIN_EN
    // 1 = B was the most recent grant. The reset value is 1 so A wins the
    // first contention.
    logic last_b_q, last_b_d;

    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        if (a_elig && b_elig) begin
            sel_a = last_b_q;
            sel_b = ~last_b_q;
        end else begin
            sel_a = a_elig;
            sel_b = b_elig;
        end
    end

    // The pointer follows every grant, whether or not there was contention.
    always_comb begin
        last_b_d = last_b_q;
        if (sel_a) begin
            last_b_d = 1'b0;
        end else if (sel_b) begin
            last_b_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`else
    always_comb begin
        sel_a = a_elig;
        sel_b = b_elig & ~a_elig;
    end
`endif

    // ------------------------------------------------------------------
    // Winner mux. At most one of sel_a/sel_b is set.
    // ------------------------------------------------------------------
    logic              win_valid;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [7:0]        win_wdata;
    logic              win_in_range;
    logic [7:0]        win_rd_val;

    always_comb begin
        win_valid = sel_a | sel_b;
        win_we    = sel_b ? b_we    : a_we;
        win_addr  = sel_b ? b_addr  : a_addr;
        win_wdata = sel_b ? b_wdata : a_wdata;
    end

    assign win_in_range = ({1'b0, win_addr} < REG_LIMIT);

    // Out-of-range reads return zero. The array is indexed only when the
    // address is known to be in range.
    always_comb begin
        win_rd_val = 8'h00;
        if (win_in_range) begin
            win_rd_val = regs_q[win_addr];
        end
    end

    // ------------------------------------------------------------------
    // Grant and read-data next state
    // ------------------------------------------------------------------
    always_comb begin
        a_gnt_d   = sel_a;
        b_gnt_d   = sel_b;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        if (sel_a && !a_we) begin
            a_rdata_d = win_rd_val;
        end
        if (sel_b && !b_we) begin
            b_rdata_d = win_rd_val;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_gnt_q   <= 1'b0;
            b_gnt_q   <= 1'b0;
            a_rdata_q <= 8'h00;
            b_rdata_q <= 8'h00;
        end else begin
            a_gnt_q   <= a_gnt_d;
            b_gnt_q   <= b_gnt_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Register file: one flop byte per entry. It is exported in parallel,
    // so it cannot live in block RAM. An out-of-range write address matches
    // no entry and is dropped.
    // ------------------------------------------------------------------
    logic win_write;

    assign win_write = win_valid & win_we;

    generate
        for (genvar gi = 0; gi < REGCOUNT; gi++) begin : g_reg
            logic [7:0] reg_d;
            logic       reg_hit;

            assign reg_hit = win_write && (win_addr == ADDR_W'(gi));

            always_comb begin
                reg_d = regs_q[gi];
                if (reg_hit) begin
                    reg_d = win_wdata;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    regs_q[gi] <= 8'h00;
                end else begin
                    regs_q[gi] <= reg_d;
                end
            end

            assign registers_packed[8*gi +: 8] = regs_q[gi];
        end
    endgenerate

    assign a_gnt   = a_gnt_q;
    assign b_gnt   = b_gnt_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_arbiter
//
// Self-checking bench for reg_arbiter. It uses REGCOUNT=12 so that the
// out-of-range addresses 12..15 are reachable. The expectations hold for
// both builds of REG_ARB_ROUND_ROBIN_EN.
//
// Each expected grant (port, and read data for reads) is pushed to sb_q
// when the stimulus is driven. The negedge monitor pops and compares one
// entry per observed grant. The scenario tasks also check the grant timing
// and the register file inline against the bench's own register model.
// ---------------------------------------------------------------------------
module tb_reg_arbiter;

    localparam int RC = 12;
    localparam int AW = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            a_req, a_we, b_req, b_we;
    logic [AW-1:0]   a_addr, b_addr;
    logic [7:0]      a_wdata, b_wdata;
    logic            a_gnt, b_gnt;
    logic [7:0]      a_rdata, b_rdata;
    logic [8*RC-1:0] registers_packed;

    reg_arbiter #(.REGCOUNT(RC), .ADDR_W(AW)) dut (
        .clock            (clock),
        .reset            (reset),
        .a_req            (a_req),
        .a_we             (a_we),
        .a_addr           (a_addr),
        .a_wdata          (a_wdata),
        .a_gnt            (a_gnt),
        .a_rdata          (a_rdata),
        .b_req            (b_req),
        .b_we             (b_we),
        .b_addr           (b_addr),
        .b_wdata          (b_wdata),
        .b_gnt            (b_gnt),
        .b_rdata          (b_rdata),
        .registers_packed (registers_packed)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       is_b;
        logic       is_read;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model [RC];
    int         compared   = 0;
    int         mismatched = 0;

    function automatic logic [8*RC-1:0] model_packed();
        logic [8*RC-1:0] p;
        for (int i = 0; i < RC; i++) p[8*i +: 8] = model[i];
        return p;
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic is_b, input logic is_read, input logic [7:0] rd);
        exp_t e;
        e.is_b    = is_b;
        e.is_read = is_read;
        e.rdata   = rd;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: one line per granted transaction.
    always @(negedge clock) begin
        if (a_gnt === 1'b1 || b_gnt === 1'b1) begin
            exp_t e;
            logic [7:0] got_rd;
            compared++;
            if (a_gnt === 1'b1 && b_gnt === 1'b1) begin
                mismatched++;
                $display("FAIL dual_grant: a_gnt=1 b_gnt=1, required at most one");
            end else if (sb_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_grant: a_gnt=%b b_gnt=%b, required no grant", a_gnt, b_gnt);
            end else begin
                e = sb_q.pop_front();
                got_rd = b_gnt ? b_rdata : a_rdata;
                if (b_gnt !== e.is_b || (e.is_read && got_rd !== e.rdata)) begin
                    mismatched++;
                    $display("FAIL grant_check: port=%s rdata=%02h, required port=%s rdata=%02h",
                             b_gnt ? "B" : "A", got_rd, e.is_b ? "B" : "A", e.rdata);
                end else begin
                    $display("grant port=%s %s rdata=%02h", b_gnt ? "B" : "A",
                             e.is_read ? "read " : "write", got_rd);
                end
            end
        end
    end

    // One uncontended access on a single port. The task checks the 1-cycle
    // latency and the register file in the grant cycle, then returns after
    // the grant cycle has ended.
    task automatic do_access(input logic port_b, input logic we, input logic [AW-1:0] addr,
                             input logic [7:0] wdata, input logic [7:0] exp_rd);
        int wait_cycles;
        logic got;
        push_exp(port_b, !we, exp_rd);
        if (port_b) begin
            b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
        end else begin
            a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
        end
        got = 1'b0;
        wait_cycles = 99;
        for (int i = 1; i <= 4 && !got; i++) begin
            cyc();
            if ((port_b ? b_gnt : a_gnt) === 1'b1) begin
                got = 1'b1;
                wait_cycles = i;
            end
        end
        compared++;
        if (wait_cycles !== 1) begin
            mismatched++;
            $display("FAIL access_latency port=%s addr=%0d: %0d cycles, required 1",
                     port_b ? "B" : "A", addr, wait_cycles);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        if (got && we && int'(addr) < RC) model[addr] = wdata;
        compared++;
        if (registers_packed !== model_packed()) begin
            mismatched++;
            $display("FAIL access_regs addr=%0d: got %h, required %h", addr,
                     registers_packed, model_packed());
        end
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd0; a_wdata = 8'h00;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd1; b_wdata = 8'h00;
        for (int i = 0; i < RC; i++) model[i] = 8'h00;
        for (int c = 0; c < 2; c++) begin
            cyc();
            compared++;
            if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || registers_packed !== '0 ||
                a_rdata !== 8'h00 || b_rdata !== 8'h00) begin
                mismatched++;
                $display("FAIL reset_state: gnt=%b%b rdata=%02h/%02h regs=%h, required all zero",
                         a_gnt, b_gnt, a_rdata, b_rdata, registers_packed);
            end
        end
        push_exp(1'b0, 1'b1, 8'h00);
        push_exp(1'b1, 1'b1, 8'h00);
        reset = 1'b0;
        cyc();
        compared++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release_c1: a_gnt=%b b_gnt=%b, required 1 0", a_gnt, b_gnt);
        end
        cyc();
        a_req = 1'b0;
        compared++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_release_c2: a_gnt=%b b_gnt=%b, required 0 1", a_gnt, b_gnt);
        end
        cyc();
        b_req = 1'b0;
        cyc();
    endtask

    task automatic test_write_read();
        do_access(1'b0, 1'b1, 4'd2, 8'h5A, 8'h00);
        compared++;
        if (registers_packed[23:16] !== 8'h5A) begin
            mismatched++;
            $display("FAIL write_reg2: got %02h, required 5a", registers_packed[23:16]);
        end
        do_access(1'b0, 1'b0, 4'd2, 8'h00, 8'h5A);
        do_access(1'b1, 1'b0, 4'd2, 8'h00, 8'h5A);
    endtask

    task automatic test_contention();
        // A B-only grant first, so that both builds give this contention to A.
        do_access(1'b1, 1'b1, 4'd9, 8'h99, 8'h00);
        push_exp(1'b0, 1'b0, 8'h00);
        push_exp(1'b1, 1'b0, 8'h00);
        a_we = 1'b1; a_addr = 4'd5; a_wdata = 8'h11; a_req = 1'b1;
        b_we = 1'b1; b_addr = 4'd5; b_wdata = 8'h22; b_req = 1'b1;
        cyc();
        compared++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || registers_packed[47:40] !== 8'h11) begin
            mismatched++;
            $display("FAIL contention_first: gnt=%b%b reg5=%02h, required gnt=10 reg5=11",
                     a_gnt, b_gnt, registers_packed[47:40]);
        end
        a_req = 1'b0;
        cyc();
        b_req = 1'b0;
        model[5] = 8'h22;
        compared++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b1 || registers_packed !== model_packed()) begin
            mismatched++;
            $display("FAIL contention_second: gnt=%b%b reg5=%02h, required gnt=01 reg5=22",
                     a_gnt, b_gnt, registers_packed[47:40]);
        end
        cyc();
    endtask

    task automatic test_sustained();
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) push_exp(1'b0, 1'b1, 8'h5A);
            else            push_exp(1'b1, 1'b1, 8'h22);
        end
        a_we = 1'b0; a_addr = 4'd2; a_req = 1'b1;
        b_we = 1'b0; b_addr = 4'd5; b_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic ea;
            cyc();
            ea = (k % 2 == 0);
            compared++;
            if (a_gnt !== ea || b_gnt !== !ea) begin
                mismatched++;
                $display("FAIL sustained_c%0d: gnt=%b%b, required %b%b", k, a_gnt, b_gnt, ea, !ea);
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_out_of_range();
        do_access(1'b1, 1'b1, 4'd13, 8'hFF, 8'h00);
        do_access(1'b1, 1'b0, 4'd13, 8'h00, 8'h00);
        do_access(1'b0, 1'b1, 4'd12, 8'hEE, 8'h00);
        do_access(1'b0, 1'b0, 4'd12, 8'h00, 8'h00);
        do_access(1'b0, 1'b1, 4'd11, 8'hC3, 8'h00);
        do_access(1'b1, 1'b0, 4'd11, 8'h00, 8'hC3);
    endtask

    task automatic test_reset_midstream();
        a_we = 1'b1; a_addr = 4'd7; a_wdata = 8'h77; a_req = 1'b1;
        reset = 1'b1;
        cyc();
        for (int i = 0; i < RC; i++) model[i] = 8'h00;
        compared++;
        if (a_gnt !== 1'b0 || registers_packed !== '0) begin
            mismatched++;
            $display("FAIL midstream_reset: a_gnt=%b regs=%h, required 0 and all zero",
                     a_gnt, registers_packed);
        end
        push_exp(1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        cyc();
        a_req = 1'b0;
        model[7] = 8'h77;
        compared++;
        if (a_gnt !== 1'b1 || registers_packed !== model_packed()) begin
            mismatched++;
            $display("FAIL midstream_release: a_gnt=%b reg7=%02h, required 1 and 77",
                     a_gnt, registers_packed[63:56]);
        end
        cyc();
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_sustained();
        test_out_of_range();
        test_reset_midstream();
        cyc();
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d grants outstanding, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/reg_arbiter.md
Name: reg_arbiter

Overview:
- Owns the chip's configuration register file and arbitrates single-cycle read/write access between two requesters: the I2C slave engine (port A) and the parallel-input capture logic (port B).
- Exports the whole file as registers_packed to the IO/PWM datapath.
- Sits inside my_chip between the I2C block and the IO block, on the divided chip clock.

Parameters:
- REGCOUNT, 16, number of 8-bit registers
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= REGCOUNT

Ports:
- clock  in  1  chip clock; all state on posedge
- reset  in  1  synchronous, active-high
- a_req  in  1  port A (I2C) access request; held until a_gnt
- a_we  in  1  port A: 1 = write, 0 = read
- a_addr  in  ADDR_W  port A register address
- a_wdata  in  8  port A write data
- a_gnt  out  1  port A grant pulse
- a_rdata  out  8  port A read data, valid while a_gnt=1
- b_req  in  1  port B (parallel) access request; held until b_gnt
- b_we  in  1  port B: 1 = write, 0 = read
- b_addr  in  ADDR_W  port B register address
- b_wdata  in  8  port B write data
- b_gnt  out  1  port B grant pulse
- b_rdata  out  8  port B read data, valid while b_gnt=1
- registers_packed  out  8*REGCOUNT  register i at bits [8i+7:8i]

Behaviour:
- Reset (sync, active-high, clock edge with reset=1):
  - All registers to 0x00.
  - a_gnt=b_gnt=0; a_rdata=b_rdata=0x00.
  - Round-robin pointer to "last granted = B", so A wins the first contention.
  - In-flight requests are dropped. Requesters must keep req asserted, and the request is served after reset deasserts.
- Eligibility: port X is eligible in cycle N if X_req=1 and X_gnt=0 in cycle N. A port can never be granted in two consecutive cycles, because its req is still high during its grant cycle.
- Selection in cycle N:
  - Exactly one eligible port: that port wins.
  - Both eligible: the policy per Optional Feature decides.
  - Neither eligible: no grant.
- Commit at the edge ending cycle N for the winner W:
  - W_gnt=1 during cycle N+1; the loser's gnt=0.
  - Write: reg[W_addr] <= W_wdata, visible on registers_packed in cycle N+1.
  - Read: W_rdata = reg[W_addr] as of cycle N (pre-edge value). W_rdata is registered and holds its value until the next read grant to that port.
  - Latency: request to grant is 1 cycle when uncontended; gnt is a 1-cycle pulse.
- Out-of-range address (addr >= REGCOUNT): write discarded, read returns 0x00. Grant still issued.
- Same-address accesses from A and B are serialized by grant order; the later write wins.
  - Example: A writes 0x11 to reg 3 (granted first), then B writes 0x22 to reg 3. Final value is 0x22.
  - A read granted after a write returns the new value.
- Guaranteed service: the no-consecutive-grant rule bounds every wait to 2 cycles, even under fixed priority.
- Registers change only on granted writes; they never change spontaneously.
- Inputs we/addr/wdata are sampled only in the cycle before the grant edge. Changes while waiting are legal and the latest values are used.

Optional Feature:
- Macro: REG_ARB_ROUND_ROBIN_EN
- Defined: on contention, grant the port not granted most recently. The pointer updates on every grant, contended or not.
- Undefined: fixed priority, A wins every contention. The pointer logic is compiled out.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with both req high -> all gnt=0, registers_packed=0. After release, A is granted in cycle 1 and B in cycle 2.
- A write then read: A writes 0x5A to addr 2 -> a_gnt next cycle, registers_packed[23:16]=0x5A. A then reads addr 2 -> a_rdata=0x5A with a_gnt.
- Contention, both writing addr 5 in the same cycle (A=0x11, B=0x22) -> A is granted first, then B. Final reg5=0x22 in both modes.
- Sustained contention, both req held for 8 cycles with no reset beforehand:
  - With REG_ARB_ROUND_ROBIN_EN: grants alternate A,B,A,B.
  - Without it: grants still alternate, because a port is never granted twice in a row.
  - After a B-only grant, the round-robin build gives the next contention to A.
- Out-of-range (REGCOUNT=12): B writes 0xFF to addr 13 -> b_gnt=1, registers unchanged. B reads addr 13 -> b_rdata=0x00.
- Reset mid-stream: assert reset in the cycle a_gnt is due -> a_gnt=0 and the write is not committed. After release, held a_req is granted and commits.
